seg_scan: RTL and testbench
===========================

# seg_scan

Digit-scan controller for the 8-digit multiplexed seven-segment display. It drives the 8-bit one-hot digit select consumed by the nibble multiplexer and supplies a frame-stable copy of the 32-bit display value, so digit select and nibble source always change together. It sits directly upstream of the nibble mux and segment decoder, and is fed by application logic that produces the hex value to show.

## Interface
Parameters:
- CNT_MAX, 50_000 — clock cycles per digit slot (1 ms at 50 MHz); legal range ≥ 1.
- BLANK_CYC, 500 — blanking cycles at the start of each slot; used only with SCAN_BLANK_EN; must satisfy BLANK_CYC < CNT_MAX.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- dig_en  in  8  per-digit enable mask; bit i gates digit i.
- data_in  in  32  value to display; nibble i belongs to digit i.
- sel  out  8  registered one-hot digit select; all-zero means no digit lit.
- data_out  out  32  registered, frame-latched copy of data_in.
- frame_start  out  1  registered one-cycle pulse when a new frame is latched.

## Operation
- Internal state:
  - div_cnt, width $clog2(CNT_MAX), minimum 1 bit, counts 0..CNT_MAX-1.
  - idx, 3 bits, digit index 0..7.
- While en=1:
  - div_cnt increments each cycle and wraps at CNT_MAX-1 to 0.
  - idx increments on each div_cnt wrap; 7 wraps to 0.
- While en=0:
  - div_cnt and idx are forced to 0.
  - sel is driven to 0.
  - data_out holds its value.
  - frame_start is 0.
- Digit select: on every edge with en=1, sel <= (1 << idx) & dig_en, using the current idx.
- Frame latch: on an edge with en=1, div_cnt==0 and idx==0:
  - data_out <= data_in;
  - frame_start <= 1 (otherwise 0).
  - This fires on the first enabled cycle after reset or after en was low, then once every 8*CNT_MAX cycles.
- data_in changes mid-frame have no effect on data_out until the next frame latch.
- A masked digit (dig_en[i]=0) keeps its full slot with sel=0. The scan timing is unchanged.
- dig_en is sampled every cycle, so mask changes take effect on the next edge.

## Timing
- Reset values: sel=8'h00, data_out=32'h0, frame_start=0, div_cnt=0, idx=0. Reset is asynchronous and valid mid-scan; all outputs clear immediately.
- Latency: 1 cycle from en high to the first nonzero sel, with data_out and frame_start updating on the same edge.
- Each digit's sel is held for exactly CNT_MAX cycles; a frame lasts 8*CNT_MAX cycles.
- sel and data_out change on the same edge, so the downstream mux never sees a mixed frame.
- en falling mid-slot: the next edge gives sel=0. Re-enabling restarts at digit 0 with a fresh latch.
- CNT_MAX=1: the digit advances every cycle and frame_start fires every 8 cycles.

## Configuration
- SCAN_BLANK_EN defined:
  - On edges where en=1 and div_cnt < BLANK_CYC, sel <= 8'h00.
  - sel is driven to (1<<idx)&dig_en only for the remaining CNT_MAX-BLANK_CYC cycles of the slot, which suppresses ghosting.
  - The frame latch and frame_start are unaffected.
- SCAN_BLANK_EN undefined: no blanking; BLANK_CYC is ignored and sel is valid for the whole slot.

## Test plan
Use CNT_MAX=4 and BLANK_CYC=1 for all scenarios.
- Reset/enable: hold rst_n=0, then release with en=0 → sel=0, data_out=0, frame_start=0. Raise en with dig_en=8'hFF and data_in=32'h1234_5678 → next edge gives sel=8'h01, data_out=32'h1234_5678, frame_start=1 for one cycle.
- Rotation: en=1 → sel steps 01,02,04,…,80,01, holding each value 4 cycles. frame_start pulses every 32 cycles, aligned with sel=8'h01.
- Frame stability: change data_in to 32'hDEAD_BEEF while sel=8'h08 → data_out stays 32'h1234_5678 until the next sel=8'h01 edge, then becomes 32'hDEAD_BEEF.
- Mask: dig_en=8'hF0 → sel=0 for slots 0–3 (4 cycles each), then 10,20,40,80 appear. Frame period stays 32.
- Mid-operation disable and reset: drop en while sel=8'h20 → next edge sel=0 and data_out held. Re-enable → sel=8'h01 with a new latch. Pulse rst_n low at an arbitrary point → all outputs 0 without waiting for a clock edge.
- Blanking (SCAN_BLANK_EN defined): each slot shows sel=0 for 1 cycle, then the one-hot value for 3 cycles. Without the macro, the one-hot value is held all 4 cycles.

Source files
------------

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
//
// Digit-scan controller for an 8-digit multiplexed seven-segment display.
// It produces a one-hot digit select and a frame-stable copy of the 32-bit
// display value. Both outputs update on the same clock edge, so the
// downstream nibble mux never pairs a digit select with a half-updated value.
//
// Parameters:
//   CNT_MAX     clock cycles per digit slot (>= 1)
//   BLANK_CYC   blanking cycles at the start of each slot (< CNT_MAX);
//               only used when SCAN_BLANK_EN is defined
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   en           in   1   scan enable
//   dig_en       in   8   per-digit enable mask (bit i gates digit i)
//   data_in      in  32   value to display, nibble i -> digit i
//   sel          out  8   registered one-hot digit select (0 = none lit)
//   data_out     out 32   registered frame-latched copy of data_in
//   frame_start  out  1   one-cycle pulse on the edge that latches a frame
//
// Build option:
//   SCAN_BLANK_EN  when defined, sel is forced to zero for the first
//                  BLANK_CYC cycles of every slot to suppress ghosting.
// ---------------------------------------------------------------------------
module seg_scan #(
    parameter int CNT_MAX   = 50_000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  dig_en,
    input  logic [31:0] data_in,
    output logic [7:0]  sel,
    output logic [31:0] data_out,
    output logic        frame_start
);

    // A one-cycle slot still needs a 1-bit counter that simply stays at 0.
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    // Elaboration-time guard against illegal parameter combinations.
    if (CNT_MAX < 1) begin : g_bad_cnt_max
        $error("seg_scan: CNT_MAX must be at least 1");
    end
    if (BLANK_CYC >= CNT_MAX) begin : g_bad_blank_cyc
        $error("seg_scan: BLANK_CYC must be smaller than CNT_MAX");
    end

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q,     idx_d;
    logic [7:0]       sel_q,     sel_d;
    logic [31:0]      data_q,    data_d;
    logic             frame_q,   frame_d;

    logic             slot_wrap;
    logic             frame_edge;
    logic             blank_now;
    logic [7:0]       onehot;

    assign slot_wrap  = (div_cnt_q == CNT_LAST);
    // The frame boundary is the first cycle of digit 0; this is also the
    // state the counters are parked in while disabled, so re-enabling always
    // begins with a fresh latch.
    assign frame_edge = (div_cnt_q == '0) && (idx_q == 3'd0);
    assign onehot     = 8'b0000_0001 << idx_q;

`ifdef SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    assign blank_now = (div_cnt_q < BLANK_LIM);
`else
    assign blank_now = 1'b0;
`endif

    // Next-state logic. sel is computed from the current idx, so it lags the
    // counters by one edge; the frame latch uses the same edge, keeping sel
    // and data_out aligned.
    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        sel_d     = 8'h00;
        data_d    = data_q;
        frame_d   = 1'b0;

        if (en) begin
            if (slot_wrap) begin
                div_cnt_d = '0;
                idx_d     = idx_q + 3'd1;
            end else begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end

            if (!blank_now) begin
                sel_d = onehot & dig_en;
            end

            if (frame_edge) begin
                data_d  = data_in;
                frame_d = 1'b1;
            end
        end else begin
            div_cnt_d = '0;
            idx_d     = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= 3'd0;
            sel_q     <= 8'h00;
            data_q    <= 32'h0;
            frame_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            frame_q   <= frame_d;
        end
    end

    assign sel         = sel_q;
    assign data_out    = data_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_scan
//
// Directed self-checking bench for seg_scan with CNT_MAX=4, BLANK_CYC=1.
// Inputs change 1 ns after a rising edge and outputs are sampled at the same
// point, well away from the active edge. Expected values come from the
// scan arithmetic: on the k-th enabled edge since the last (re)start, the
// slot counter is k%4 and the digit is (k/4)%8.
// ---------------------------------------------------------------------------
module tb_seg_scan;

    localparam int CNT_MAX   = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME_LEN = 8 * CNT_MAX;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  dig_en;
    logic [31:0] data_in;
    logic [7:0]  sel;
    logic [31:0] data_out;
    logic        frame_start;

    int          testsRun;
    int          testsFailed;
    int          k;
    logic [31:0] expData;

    seg_scan #(
        .CNT_MAX   (CNT_MAX),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .dig_en      (dig_en),
        .data_in     (data_in),
        .sel         (sel),
        .data_out    (data_out),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s (cycle %0d): got %h, expected %h",
                     tag, k, actual, expected);
        end
    endtask

    // Expected sel on the k-th enabled edge.
    function automatic logic [7:0] expSel(input int kk, input logic [7:0] mask);
        logic [7:0] oneHot;
        oneHot = 8'b0000_0001 << ((kk / CNT_MAX) % 8);
`ifdef SCAN_BLANK_EN
        if ((kk % CNT_MAX) < BLANK_CYC) oneHot = 8'h00;
`endif
        return oneHot & mask;
    endfunction

    // One clock edge: capture inputs seen by the edge, then check all outputs.
    task automatic applyStimulus();
        logic        enB;
        logic [7:0]  maskB;
        logic [31:0] dataB;
        logic [7:0]  selE;
        logic        frameE;
        enB   = en;
        maskB = dig_en;
        dataB = data_in;
        @(posedge clk);
        #1;
        if (!enB) begin
            selE   = 8'h00;
            frameE = 1'b0;
            k      = 0;
        end else begin
            frameE = ((k % FRAME_LEN) == 0);
            if (frameE) expData = dataB;
            selE = expSel(k, maskB);
        end
        checkOutput("sel", {24'h0, sel}, {24'h0, selE});
        checkOutput("frame_start", {31'h0, frame_start}, {31'h0, frameE});
        checkOutput("data_out", data_out, expData);
        if (enB) k++;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        k           = 0;
        expData     = 32'h0;
        rst_n       = 1'b0;
        en          = 1'b0;
        dig_en      = 8'hFF;
        data_in     = 32'h1234_5678;

        // Reset values while reset is asserted.
        #12;
        checkOutput("rst_sel", {24'h0, sel}, 32'h0);
        checkOutput("rst_data", data_out, 32'h0);
        checkOutput("rst_frame", {31'h0, frame_start}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Disabled after reset: everything stays quiet.
        runCycles(3);

        // Enable: first edge lights digit 0 and latches the frame.
        en = 1'b1;
        applyStimulus();
`ifdef SCAN_BLANK_EN
        checkOutput("first_sel", {24'h0, sel}, 32'h0);
`else
        checkOutput("first_sel", {24'h0, sel}, 32'h01);
`endif
        checkOutput("first_data", data_out, 32'h1234_5678);
        checkOutput("first_frame", {31'h0, frame_start}, 32'h1);

        // Rotate into digit 3, then change data mid-frame.
        runCycles(13);
        checkOutput("slot3_sel", {24'h0, sel}, 32'h08);
        data_in = 32'hDEAD_BEEF;
        runCycles(18);
        checkOutput("hold_data", data_out, 32'h1234_5678);
        checkOutput("hold_frame", {31'h0, frame_start}, 32'h0);
        runCycles(1);
        checkOutput("new_data", data_out, 32'hDEAD_BEEF);
        checkOutput("new_frame", {31'h0, frame_start}, 32'h1);

        // Finish frame 1, then a full frame with the upper four digits only.
        runCycles(31);
        dig_en = 8'hF0;
        runCycles(32);
        dig_en = 8'hFF;

        // Advance into digit 5 and drop enable.
        runCycles(22);
        checkOutput("slot5_sel", {24'h0, sel}, 32'h20);
        en = 1'b0;
        applyStimulus();
        checkOutput("dis_sel", {24'h0, sel}, 32'h0);
        checkOutput("dis_data", data_out, 32'hDEAD_BEEF);
        runCycles(2);

        // Re-enable with new data: restart at digit 0 with a fresh latch.
        data_in = 32'hCAFE_F00D;
        en      = 1'b1;
        applyStimulus();
`ifdef SCAN_BLANK_EN
        checkOutput("reen_sel", {24'h0, sel}, 32'h0);
`else
        checkOutput("reen_sel", {24'h0, sel}, 32'h01);
`endif
        checkOutput("reen_data", data_out, 32'hCAFE_F00D);
        checkOutput("reen_frame", {31'h0, frame_start}, 32'h1);
        runCycles(10);

        // Asynchronous reset mid-slot: outputs clear before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_sel", {24'h0, sel}, 32'h0);
        checkOutput("async_data", data_out, 32'h0);
        checkOutput("async_frame", {31'h0, frame_start}, 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        k       = 0;
        expData = 32'h0;
        data_in = 32'h0BAD_F00D;

        // Scan restarts from digit 0 after reset with en still high.
        runCycles(40);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
